// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: opcodes, ALU operation codes, default widths.
package exec_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_IMM_W = 7;
  localparam int unsigned OPC_W     = 3;
  localparam int unsigned FUNC_W    = 4;
  localparam int unsigned ALU_W     = 3;

  // Major opcodes (instruction[15:13])
  localparam logic [OPC_W-1:0] OP_RTYPE = 3'b000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_LW    = 3'b010;
  localparam logic [OPC_W-1:0] OP_SW    = 3'b011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 3'b100;
  localparam logic [OPC_W-1:0] OP_JMP   = 3'b101;
  localparam logic [OPC_W-1:0] OP_ANDI  = 3'b110;
  localparam logic [OPC_W-1:0] OP_ORI   = 3'b111;

  // ALU operation codes (also the R-type func[2:0] encoding)
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SRL = 3'b111;

endpackage

// File: rtl/exec_alu_core.sv
// Combinational ALU: eight operations, carry/no-borrow flag and zero flag.
module exec_alu_core
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [ALU_W-1:0] i_alu_code,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0] w_sum;

  // Operation select; subtraction is A + ~B + 1 so bit WIDTH reads as "no borrow"
  always_comb begin
    w_sum    = '0;
    o_result = '0;
    o_carry  = 1'b0;
    case (i_alu_code)
      ALU_ADD: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b};
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      ALU_SUB: begin
        w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      ALU_SLL: o_result = i_a << i_b[SHW-1:0];
      ALU_SRL: o_result = i_a >> i_b[SHW-1:0];
      default: o_result = '0;
    endcase
  end

  // Zero flag always reflects the final result
  assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU-control decode, B-operand mux, ALU, and registered status copy.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned IMM_W = DEF_IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  read1,
  input  logic [WIDTH-1:0]  read2,
  input  logic [IMM_W-1:0]  immediate,
  input  logic              alu_src,
  output logic [ALU_W-1:0]  alu_code,
  output logic [WIDTH-1:0]  alu_result,
  output logic              carry,
  output logic              is_zero,
  output logic              illegal_op,
  output logic [WIDTH-1:0]  result_q,
  output logic              carry_q,
  output logic              zero_q
);

  logic [ALU_W-1:0] w_alu_code;
  logic             w_illegal;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_zero;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;

  // Opcode/func to ALU operation; unknown R-type funcs fall back to ADD and flag illegal
  always_comb begin
    w_alu_code = ALU_ADD;
    w_illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (func[FUNC_W-1]) begin
          w_alu_code = ALU_ADD;
          w_illegal  = 1'b1;
        end else begin
          w_alu_code = func[ALU_W-1:0];
        end
      end
      OP_ADDI: w_alu_code = ALU_ADD;
      OP_LW:   w_alu_code = ALU_ADD;
      OP_SW:   w_alu_code = ALU_ADD;
      OP_BEQ:  w_alu_code = ALU_SUB;
      OP_JMP:  w_alu_code = ALU_ADD;
      OP_ANDI: w_alu_code = ALU_AND;
      OP_ORI:  w_alu_code = ALU_OR;
      default: w_alu_code = ALU_ADD;
    endcase
  end

  // Immediate is sign-extended for every immediate op, logical ones included
  assign w_imm_ext = {{(WIDTH-IMM_W){immediate[IMM_W-1]}}, immediate};
  assign w_b       = alu_src ? w_imm_ext : read2;

  exec_alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_a        (read1),
    .i_b        (w_b),
    .i_alu_code (w_alu_code),
    .o_result   (w_result),
    .o_carry    (w_carry),
    .o_zero     (w_zero)
  );

  // Status/debug copy of the ALU outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_result <= w_result;
      r_carry  <= w_carry;
      r_zero   <= w_zero;
    end
  end

  assign alu_code   = w_alu_code;
  assign illegal_op = w_illegal;
  assign alu_result = w_result;
  assign carry      = w_carry;
  assign is_zero    = w_zero;
  assign result_q   = r_result;
  assign carry_q    = r_carry;
  assign zero_q     = r_zero;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus a random pipelined stream.
module tb_execute_stage;

  typedef struct packed {
    logic [15:0] res;
    logic        c;
    logic        z;
  } reg_exp_t;

  typedef struct packed {
    logic [2:0]  code;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        ill;
  } comb_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  opcode;
  logic [3:0]  func;
  logic [15:0] read1;
  logic [15:0] read2;
  logic [6:0]  immediate;
  logic        alu_src;
  logic [2:0]  alu_code;
  logic [15:0] alu_result;
  logic        carry;
  logic        is_zero;
  logic        illegal_op;
  logic [15:0] result_q;
  logic        carry_q;
  logic        zero_q;

  int ntests = 0;
  int nfail  = 0;
  reg_exp_t sb[$];

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func       (func),
    .read1      (read1),
    .read2      (read2),
    .immediate  (immediate),
    .alu_src    (alu_src),
    .alu_code   (alu_code),
    .alu_result (alu_result),
    .carry      (carry),
    .is_zero    (is_zero),
    .illegal_op (illegal_op),
    .result_q   (result_q),
    .carry_q    (carry_q),
    .zero_q     (zero_q)
  );

  always #5 clk = ~clk;

  // Reference model written from the instruction-set description
  function automatic comb_exp_t model(input logic [2:0] op, input logic [3:0] fn,
                                     input logic [15:0] a, input logic [15:0] r2,
                                     input logic [6:0] imm, input logic src);
    comb_exp_t   e;
    logic [15:0] b;
    logic [31:0] wide;
    int          simm;
    simm = imm[6] ? int'(imm) - 128 : int'(imm);
    b    = src ? 16'(simm) : r2;
    e.ill = (op == 3'd0) && fn[3];
    case (op)
      3'd0:    e.code = fn[3] ? 3'd0 : fn[2:0];
      3'd4:    e.code = 3'd1;
      3'd6:    e.code = 3'd2;
      3'd7:    e.code = 3'd3;
      default: e.code = 3'd0;
    endcase
    e.c = 1'b0;
    case (e.code)
      3'd0: begin wide = 32'(a) + 32'(b); e.res = wide[15:0]; e.c = wide[16]; end
      3'd1: begin e.res = a - b; e.c = (a >= b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
      3'd6: e.res = a << b[3:0];
      default: e.res = a >> b[3:0];
    endcase
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  // Drive one instruction's operands just after a falling edge and let them settle
  task automatic drive(input logic [2:0] op, input logic [3:0] fn, input logic [15:0] a,
                       input logic [15:0] b, input logic [6:0] imm, input logic src);
    @(negedge clk);
    opcode = op; func = fn; read1 = a; read2 = b; immediate = imm; alu_src = src;
    #1;
  endtask

  task automatic test_reset;
    reg_exp_t e;
    rst = 1'b1;
    drive(3'b001, 4'h0, 16'h0003, 16'h0000, 7'h04, 1'b1);
    sb.push_back('{res: 16'h0, c: 1'b0, z: 1'b0});
    ntests++;
    if ({alu_code, alu_result, carry, is_zero, illegal_op} !== {3'd0, 16'h0007, 1'b0, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL reset_comb: got %h expected %h", {alu_code, alu_result, carry, is_zero, illegal_op},
               {3'd0, 16'h0007, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    ntests++;
    if ({result_q, carry_q, zero_q} !== e) begin
      nfail++;
      $display("FAIL reset_regs: got %h expected %h", {result_q, carry_q, zero_q}, e);
    end
    rst = 1'b0;
    drive(3'b001, 4'h0, 16'h0003, 16'h0000, 7'h04, 1'b1);
    sb.push_back('{res: 16'h0007, c: 1'b0, z: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    ntests++;
    if ({result_q, carry_q, zero_q} !== e) begin
      nfail++;
      $display("FAIL reset_release: got %h expected %h", {result_q, carry_q, zero_q}, e);
    end
  endtask

  task automatic test_rtype_add;
    reg_exp_t e;
    drive(3'b000, 4'b0000, 16'hFFFF, 16'h0001, 7'h00, 1'b0);
    sb.push_back('{res: 16'h0000, c: 1'b1, z: 1'b1});
    ntests++;
    if ({alu_code, alu_result, carry, is_zero, illegal_op} !== {3'd0, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL rtype_add_comb: got %h expected %h", {alu_code, alu_result, carry, is_zero, illegal_op},
               {3'd0, 16'h0000, 1'b1, 1'b1, 1'b0});
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    ntests++;
    if ({result_q, carry_q, zero_q} !== e) begin
      nfail++;
      $display("FAIL rtype_add_regs: got %h expected %h", {result_q, carry_q, zero_q}, e);
    end
  endtask

  task automatic test_beq;
    drive(3'b100, 4'h0, 16'h0005, 16'h0005, 7'h00, 1'b0);
    ntests++;
    if ({alu_code, alu_result, carry, is_zero, illegal_op} !== {3'd1, 16'h0000, 1'b1, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL beq_equal: got %h expected %h", {alu_code, alu_result, carry, is_zero, illegal_op},
               {3'd1, 16'h0000, 1'b1, 1'b1, 1'b0});
    end
    drive(3'b100, 4'h0, 16'h0005, 16'h0006, 7'h00, 1'b0);
    ntests++;
    if ({alu_code, alu_result, carry, is_zero, illegal_op} !== {3'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL beq_borrow: got %h expected %h", {alu_code, alu_result, carry, is_zero, illegal_op},
               {3'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_addi;
    drive(3'b001, 4'h0, 16'h0010, 16'h1234, 7'h7F, 1'b1);
    ntests++;
    if ({alu_code, alu_result, carry, is_zero} !== {3'd0, 16'h000F, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL addi_neg_imm: got %h expected %h", {alu_code, alu_result, carry, is_zero},
               {3'd0, 16'h000F, 1'b1, 1'b0});
    end
    drive(3'b001, 4'h0, 16'h0010, 16'h1234, 7'h05, 1'b1);
    ntests++;
    if ({alu_code, alu_result, carry, is_zero} !== {3'd0, 16'h0015, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL addi_pos_imm: got %h expected %h", {alu_code, alu_result, carry, is_zero},
               {3'd0, 16'h0015, 1'b0, 1'b0});
    end
  endtask

  task automatic test_shifts;
    logic [3:0]  fns[3]  = '{4'b0101, 4'b0110, 4'b0111};
    logic [15:0] exps[3] = '{16'h0001, 16'h0008, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, fns[i], 16'h8001, 16'h0003, 7'h00, 1'b0);
      ntests++;
      if ({alu_code, alu_result, carry, illegal_op} !== {fns[i][2:0], exps[i], 1'b0, 1'b0}) begin
        nfail++;
        $display("FAIL shift_slt_%0d: got %h expected %h", i, {alu_code, alu_result, carry, illegal_op},
                 {fns[i][2:0], exps[i], 1'b0, 1'b0});
      end
    end
    // Shift amount 0 passes A; only B[3:0] counts (0x0010 -> 0, 0x0013 -> 3)
    drive(3'b000, 4'b0110, 16'hA5C3, 16'h0010, 7'h00, 1'b0);
    ntests++;
    if (alu_result !== 16'hA5C3) begin
      nfail++;
      $display("FAIL shift_zero: got %h expected %h", alu_result, 16'hA5C3);
    end
    drive(3'b000, 4'b0111, 16'hA5C3, 16'h0013, 7'h00, 1'b0);
    ntests++;
    if (alu_result !== 16'h14B8) begin
      nfail++;
      $display("FAIL shift_hibits: got %h expected %h", alu_result, 16'h14B8);
    end
  endtask

  task automatic test_illegal_andi;
    drive(3'b000, 4'b1010, 16'h0003, 16'h0004, 7'h00, 1'b0);
    ntests++;
    if ({alu_code, alu_result, illegal_op} !== {3'd0, 16'h0007, 1'b1}) begin
      nfail++;
      $display("FAIL illegal_func: got %h expected %h", {alu_code, alu_result, illegal_op},
               {3'd0, 16'h0007, 1'b1});
    end
    drive(3'b110, 4'b1111, 16'hFFFF, 16'h0000, 7'h40, 1'b1);
    ntests++;
    if ({alu_code, alu_result, carry, is_zero, illegal_op} !== {3'd2, 16'hFFC0, 1'b0, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL andi_sext: got %h expected %h", {alu_code, alu_result, carry, is_zero, illegal_op},
               {3'd2, 16'hFFC0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  // Random back-to-back stream with a mid-stream reset pulse; registers checked via scoreboard
  task automatic test_back_to_back;
    comb_exp_t ce;
    reg_exp_t  e;
    logic [2:0]  op;
    logic [3:0]  fn;
    logic [15:0] a, b;
    logic [6:0]  imm;
    logic        src;
    for (int i = 0; i < 200; i++) begin
      op  = 3'($urandom_range(0, 7));
      fn  = 4'($urandom_range(0, 15));
      a   = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
      b   = (i % 5 == 0) ? a : 16'($urandom);
      imm = 7'($urandom);
      src = 1'($urandom);
      rst = (i == 60 || i == 61);
      drive(op, fn, a, b, imm, src);
      ce = model(op, fn, a, b, imm, src);
      if (rst) sb.push_back('{res: 16'h0, c: 1'b0, z: 1'b0});
      else     sb.push_back('{res: ce.res, c: ce.c, z: ce.z});
      ntests++;
      if ({alu_code, alu_result, carry, is_zero, illegal_op} !== ce) begin
        nfail++;
        $display("FAIL b2b_comb_%0d: got %h expected %h", i, {alu_code, alu_result, carry, is_zero, illegal_op}, ce);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      ntests++;
      if ({result_q, carry_q, zero_q} !== e) begin
        nfail++;
        $display("FAIL b2b_regs_%0d: got %h expected %h", i, {result_q, carry_q, zero_q}, e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; func = '0; read1 = '0; read2 = '0; immediate = '0; alu_src = 1'b0;
    test_reset;
    test_rtype_add;
    test_beq;
    test_addi;
    test_shifts;
    test_illegal_andi;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
